// File: rtl/nios2_debug_monitor_mem_bridge.sv
// Debug monitor memory bridge: executes single-word debug reads and writes
// requested by the JTAG debug slave wrapper over an Avalon-MM master.
module nios2_debug_monitor_mem_bridge #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              cmd_overrun,
  output logic [ADDR_W+1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int unsigned CntW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit          TimeoutEn = (TIMEOUT != 0);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e            state_q, state_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              overrun_q, overrun_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              any_strobe;

  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

  // Requests come straight from the state register, so strobes never reach avm_* combinationally.
  assign avm_read       = (state_q == StRead);
  assign avm_write      = (state_q == StWrite);
  assign avm_address    = {mon_a_q, 2'b00};
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = 4'hF;
  assign MonDReg        = mon_d_q;
  assign MonAReg        = mon_a_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = error_q;
  assign cmd_overrun    = overrun_q;

  // Next-state: command decode in idle, handshake/timeout while a request is outstanding.
  always_comb begin
    state_d   = state_q;
    mon_d_d   = mon_d_q;
    mon_a_d   = mon_a_q;
    ready_d   = ready_q;
    error_d   = error_q;
    overrun_d = overrun_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (take_action_ocimem_b) begin
          wdata_d = jdo[34:3];
          state_d = StWrite;
          ready_d = 1'b0;
          error_d = 1'b0;
          cnt_d   = '0;
        end else if (take_action_ocimem_a) begin
          mon_a_d = jdo[ADDR_W+16:17];
          error_d = 1'b0;
          cnt_d   = '0;
          if (jdo[34]) begin
            state_d = StRead;
            ready_d = 1'b0;
          end else begin
            // Address load only: complete immediately.
            ready_d = 1'b1;
          end
        end else if (take_no_action_ocimem_a) begin
          state_d = StRead;
          ready_d = 1'b0;
          error_d = 1'b0;
          cnt_d   = '0;
        end
      end
      StRead, StWrite: begin
        if (any_strobe) begin
          overrun_d = 1'b1;
        end
        // A completing handshake wins over a timeout landing in the same cycle.
        if (!avm_waitrequest) begin
          if (state_q == StRead) begin
            mon_d_d = avm_readdata;
          end
          mon_a_d = mon_a_q + ADDR_W'(1);
          ready_d = 1'b1;
          state_d = StIdle;
        end else if (TimeoutEn && (cnt_q == CntLast)) begin
          error_d = 1'b1;
          ready_d = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and register file with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      mon_d_q   <= '0;
      mon_a_q   <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mon_d_q   <= mon_d_d;
      mon_a_q   <= mon_a_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_nios2_debug_monitor_mem_bridge.sv
// Self-checking bench for the debug monitor memory bridge: directed vector table,
// hand sequences for reset-in-flight, then random commands against a transaction model.
module tb_nios2_debug_monitor_mem_bridge;

  localparam int unsigned AW = 16;
  localparam int unsigned TO = 8;

  logic          clk, reset;
  logic [37:0]   jdo;
  logic          take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [31:0]   MonDReg;
  logic [AW-1:0] MonAReg;
  logic          monitor_ready, monitor_error, cmd_overrun;
  logic [AW+1:0] avm_address;
  logic          avm_read, avm_write;
  logic [31:0]   avm_writedata;
  logic [3:0]    avm_byteenable;
  logic [31:0]   avm_readdata;
  logic          avm_waitrequest;

  nios2_debug_monitor_mem_bridge #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b   (take_action_ocimem_b),
    .MonDReg                (MonDReg),
    .MonAReg                (MonAReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error),
    .cmd_overrun            (cmd_overrun),
    .avm_address            (avm_address),
    .avm_read               (avm_read),
    .avm_write              (avm_write),
    .avm_writedata          (avm_writedata),
    .avm_byteenable         (avm_byteenable),
    .avm_readdata           (avm_readdata),
    .avm_waitrequest        (avm_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // stb = {ocimem_b, ocimem_a, no_action_a}; inject = request cycle on which to fire
  // all strobes while busy (0 = never).
  typedef struct {
    logic [2:0]    stb;
    logic [37:0]   jdo;
    int            stalls;
    logic [31:0]   rdata;
    int            inject;
    int            exp_n;
    logic [AW+1:0] exp_addr;
    logic [31:0]   exp_wdata;
    bit            exp_wr;
    logic [AW-1:0] exp_mona;
    logic [31:0]   exp_mond;
    bit            exp_rdy;
    bit            exp_err;
    bit            exp_ovr;
  } vec_t;

  typedef struct {
    int            n;
    logic [AW+1:0] addr;
    logic [31:0]   wdata;
    bit            was_write;
    int            glitches;
  } obs_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] mk_a(input logic [15:0] a, input bit rd);
    return {3'b000, rd, 1'b0, a, 17'h0};
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    return {3'b000, d, 3'b000};
  endfunction

  function automatic vec_t mkv(input logic [2:0] stb, input logic [37:0] j, input int stalls,
                               input logic [31:0] rdata, input int inject, input int en,
                               input logic [AW+1:0] addr, input logic [31:0] wdata, input bit wr,
                               input logic [AW-1:0] mona, input logic [31:0] mond,
                               input bit rdy, input bit err, input bit ovr);
    vec_t v;
    v.stb = stb; v.jdo = j; v.stalls = stalls; v.rdata = rdata; v.inject = inject;
    v.exp_n = en; v.exp_addr = addr; v.exp_wdata = wdata; v.exp_wr = wr;
    v.exp_mona = mona; v.exp_mond = mond; v.exp_rdy = rdy; v.exp_err = err; v.exp_ovr = ovr;
    return v;
  endfunction

  task automatic clear_strobes();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
  endtask

  // Issue one command and act as an Avalon slave until the request is dropped.
  task automatic run_cmd(input vec_t v, output obs_t o);
    logic [63:0] r;
    o.n = 0; o.addr = '0; o.wdata = '0; o.was_write = 1'b0; o.glitches = 0;
    @(negedge clk);
    take_action_ocimem_b    = v.stb[2];
    take_action_ocimem_a    = v.stb[1];
    take_no_action_ocimem_a = v.stb[0];
    jdo = v.jdo;
    avm_waitrequest = 1'b1;
    @(negedge clk);
    clear_strobes();
    for (int cyc = 0; cyc < 200 && (avm_read || avm_write); cyc++) begin
      o.n++;
      if (o.n == 1) begin
        o.addr = avm_address; o.wdata = avm_writedata; o.was_write = avm_write;
      end else if (avm_address !== o.addr || avm_writedata !== o.wdata ||
                   avm_write !== o.was_write) begin
        o.glitches++;
      end
      if (avm_read && avm_write) o.glitches++;
      if (monitor_ready !== 1'b0 || monitor_error !== 1'b0) o.glitches++;
      if (avm_byteenable !== 4'hF) o.glitches++;
      avm_waitrequest = (o.n <= v.stalls);
      avm_readdata = avm_waitrequest ? $urandom : v.rdata;
      if (o.n == v.inject) begin
        take_action_ocimem_b = 1'b1; take_action_ocimem_a = 1'b1; take_no_action_ocimem_a = 1'b1;
        r = {$urandom, $urandom};
        jdo = r[37:0];
      end
      @(negedge clk);
      clear_strobes();
    end
  endtask

  task automatic verify(input string tag, input vec_t v, input obs_t o);
    check({tag, " req_cycles"}, 64'(o.n), 64'(v.exp_n));
    if (v.exp_n > 0) begin
      check({tag, " address"}, 64'(o.addr), 64'(v.exp_addr));
      check({tag, " is_write"}, 64'(o.was_write), 64'(v.exp_wr));
      if (v.exp_wr) check({tag, " writedata"}, 64'(o.wdata), 64'(v.exp_wdata));
    end
    check({tag, " bus_glitches"}, 64'(o.glitches), 64'd0);
    check({tag, " MonAReg"}, 64'(MonAReg), 64'(v.exp_mona));
    check({tag, " MonDReg"}, 64'(MonDReg), 64'(v.exp_mond));
    check({tag, " ready"}, 64'(monitor_ready), 64'(v.exp_rdy));
    check({tag, " error"}, 64'(monitor_error), 64'(v.exp_err));
    check({tag, " overrun"}, 64'(cmd_overrun), 64'(v.exp_ovr));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " avm_read"}, 64'(avm_read), 64'd0);
    check({tag, " avm_write"}, 64'(avm_write), 64'd0);
    check({tag, " writedata"}, 64'(avm_writedata), 64'd0);
    check({tag, " MonAReg"}, 64'(MonAReg), 64'd0);
    check({tag, " MonDReg"}, 64'(MonDReg), 64'd0);
    check({tag, " ready"}, 64'(monitor_ready), 64'd0);
    check({tag, " error"}, 64'(monitor_error), 64'd0);
    check({tag, " overrun"}, 64'(cmd_overrun), 64'd0);
  endtask

  // Transaction-level reference model state.
  logic [AW-1:0] m_a;
  logic [31:0]   m_d;
  logic [31:0]   m_w;
  bit            m_rdy, m_err, m_ovr;

  task automatic model_reset();
    m_a = '0; m_d = '0; m_w = '0; m_rdy = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
  endtask

  // Fill expectations from the command rules: priority b > a > no_action, TO request
  // cycles at most, address advances only on a completed access.
  task automatic model_cmd(inout vec_t v);
    bit access, wr, tout;
    wr = v.stb[2];
    access = 1'b1;
    if (wr) begin
      m_w = v.jdo[34:3];
    end else if (v.stb[1]) begin
      m_a = v.jdo[AW+16:17];
      access = v.jdo[34];
    end
    v.exp_wr = wr;
    v.exp_wdata = m_w;
    v.exp_addr = {m_a, 2'b00};
    if (access) begin
      tout = (v.stalls >= TO);
      v.exp_n = tout ? TO : v.stalls + 1;
      if (!tout) begin
        if (!wr) m_d = v.rdata;
        m_a = m_a + 1'b1;
      end
      m_err = tout;
      if (v.inject >= 1 && v.inject <= v.exp_n) m_ovr = 1'b1;
    end else begin
      v.exp_n = 0;
      m_err = 1'b0;
    end
    m_rdy = 1'b1;
    v.exp_mona = m_a; v.exp_mond = m_d; v.exp_rdy = m_rdy; v.exp_err = m_err; v.exp_ovr = m_ovr;
  endtask

  vec_t tbl[10];

  initial begin
    vec_t v;
    obs_t o;
    logic [63:0] r;

    tbl[0] = mkv(3'b010, mk_a(16'h0040, 1'b0), 0, 32'h0, 0,
                 0, 18'h0, 32'h0, 1'b0, 16'h0040, 32'h0, 1'b1, 1'b0, 1'b0);
    tbl[1] = mkv(3'b100, mk_b(32'hDEADBEEF), 3, 32'h0, 0,
                 4, 18'h00100, 32'hDEADBEEF, 1'b1, 16'h0041, 32'h0, 1'b1, 1'b0, 1'b0);
    tbl[2] = mkv(3'b001, 38'h3F_FFFF_FFFF, 0, 32'h12345678, 0,
                 1, 18'h00104, 32'h0, 1'b0, 16'h0042, 32'h12345678, 1'b1, 1'b0, 1'b0);
    tbl[3] = mkv(3'b010, mk_a(16'hFFFF, 1'b1), 1, 32'hCAFEF00D, 0,
                 2, 18'h3FFFC, 32'h0, 1'b0, 16'h0000, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);
    tbl[4] = mkv(3'b001, 38'h0, 20, 32'h11111111, 0,
                 8, 18'h00000, 32'h0, 1'b0, 16'h0000, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0);
    tbl[5] = mkv(3'b001, 38'h0, 7, 32'h0BADC0DE, 0,
                 8, 18'h00000, 32'h0, 1'b0, 16'h0001, 32'h0BADC0DE, 1'b1, 1'b0, 1'b0);
    tbl[6] = mkv(3'b111, mk_b(32'h80000001), 2, 32'h0, 0,
                 3, 18'h00004, 32'h80000001, 1'b1, 16'h0002, 32'h0BADC0DE, 1'b1, 1'b0, 1'b0);
    tbl[7] = mkv(3'b011, mk_a(16'h1234, 1'b0), 0, 32'h0, 0,
                 0, 18'h0, 32'h0, 1'b0, 16'h1234, 32'h0BADC0DE, 1'b1, 1'b0, 1'b0);
    tbl[8] = mkv(3'b001, 38'h0, 4, 32'h600DF00D, 2,
                 5, 18'h048D0, 32'h0, 1'b0, 16'h1235, 32'h600DF00D, 1'b1, 1'b0, 1'b1);
    tbl[9] = mkv(3'b100, mk_b(32'h13572468), 30, 32'h0, 0,
                 8, 18'h048D4, 32'h13572468, 1'b1, 16'h1235, 32'h600DF00D, 1'b1, 1'b1, 1'b1);

    clear_strobes();
    jdo = '0; avm_readdata = '0; avm_waitrequest = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_cmd(tbl[i], o);
      verify($sformatf("vec%0d", i), tbl[i], o);
    end

    // Reset asserted while a read is stalled: everything drops immediately.
    @(negedge clk);
    take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    clear_strobes();
    avm_waitrequest = 1'b1;
    @(negedge clk);
    check("midreset read_active", 64'(avm_read), 64'd1);
    #2 reset = 1'b1;
    #1 check_reset_values("midreset");
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 60; i++) begin
      r = {$urandom, $urandom};
      v.stb = 3'($urandom_range(1, 7));
      v.jdo = r[37:0];
      if (i % 4 == 0) v.jdo[34] = 1'b1;
      v.stalls = $urandom_range(0, 10);
      v.rdata = $urandom;
      v.inject = $urandom_range(0, 6);
      model_cmd(v);
      run_cmd(v, o);
      verify($sformatf("rnd%0d", i), v, o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nios2_debug_monitor_mem_bridge.md
Name: nios2_debug_monitor_mem_bridge

Overview:
- System-clock-domain stage directly downstream of the CPU debug slave wrapper.
- Consumes jdo and the take_action_ocimem_a/b and take_no_action_ocimem_a strobes.
- Executes single-word debug reads and writes over an Avalon-MM master.
- Returns MonDReg, monitor_ready and monitor_error, which feed back into the wrapper's capture path.

Parameters:
ADDR_W, 16, word-address width of the debug window (byte address = {MonAReg, 2'b00})
TIMEOUT, 1024, max cycles one access may stall on waitrequest; 0 disables the timeout

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
jdo  in  38  JTAG data captured into the clk domain
take_action_ocimem_a  in  1  1-cycle strobe: address load, optional read
take_no_action_ocimem_a  in  1  1-cycle strobe: read at current address
take_action_ocimem_b  in  1  1-cycle strobe: write
MonDReg  out  32  last read data
MonAReg  out  ADDR_W  current word address
monitor_ready  out  1  last command complete
monitor_error  out  1  last command timed out
cmd_overrun  out  1  sticky: a strobe arrived while busy
avm_address  out  ADDR_W+2  byte address
avm_read  out  1  Avalon read request
avm_write  out  1  Avalon write request
avm_writedata  out  32  write data
avm_byteenable  out  4  constant 4'hF
avm_readdata  in  32  read data (zero-latency, valid with !waitrequest)
avm_waitrequest  in  1  slave stall

Behaviour:
- Reset (async, any state): state=IDLE; MonDReg=0; MonAReg=0; monitor_ready=0; monitor_error=0; cmd_overrun=0; avm_read=0; avm_write=0; avm_writedata=0; timeout counter=0.
- Command decode in IDLE only; strobe priority when several are high in one cycle: ocimem_b > ocimem_a > no_action_a.
  - ocimem_b: avm_writedata <= jdo[34:3]; go to WRITE.
  - ocimem_a: MonAReg <= jdo[ADDR_W+16:17]. If jdo[34]=1, go to READ at the new address; otherwise stay IDLE, monitor_ready=1 next cycle.
  - no_action_a: go to READ at current MonAReg.
- On accepting any command: monitor_ready<=0; monitor_error<=0; counter<=0.
- READ/WRITE states:
  - avm_read (resp. avm_write) asserted from the cycle after acceptance and held, with address and data stable, until the cycle with avm_waitrequest=0.
  - Read completion cycle: MonDReg<=avm_readdata.
  - Completion: drop request; MonAReg<=MonAReg+1 (wraps modulo 2^ADDR_W); monitor_ready<=1; return to IDLE.
  - Minimum latency strobe->monitor_ready high is 2 cycles (waitrequest low on first request cycle).
- Timeout (TIMEOUT>0):
  - Counter increments each request cycle with waitrequest=1.
  - When counter = TIMEOUT-1 and waitrequest is still 1: drop request that cycle; monitor_error<=1; monitor_ready<=1; MonDReg unchanged; no address increment; return to IDLE.
- Strobe while in READ/WRITE: ignored (no state or register change); cmd_overrun<=1 (sticky; cleared only by reset).
- avm_read and avm_write are never both high.
- No combinational path from strobes to avm_* outputs.

Test Plan:
1. Reset, then ocimem_a with jdo[32:17]=16'h0040, jdo[34]=0 -> MonAReg=0x0040; monitor_ready=1 one cycle later; no avm activity.
2. ocimem_b with jdo[34:3]=32'hDEADBEEF, waitrequest high for 3 cycles -> avm_write high 4 cycles at avm_address=0x00100, writedata=DEADBEEF; then MonAReg=0x0041, monitor_ready=1.
3. no_action_a with readdata=32'h12345678, waitrequest=0 -> avm_read for 1 cycle at 0x00104; MonDReg=12345678; MonAReg=0x0042; ready 2 cycles after strobe.
4. MonAReg=0xFFFF, then a read completes -> MonAReg wraps to 0x0000.
5. TIMEOUT=8, waitrequest stuck high -> avm_read drops after 8 cycles; monitor_error=1, monitor_ready=1; MonAReg and MonDReg unchanged. The next command clears monitor_error.
6. Strobe ocimem_b during a stalled read -> ignored, cmd_overrun=1. Assert reset mid-read -> avm_read=0 immediately, all outputs at reset values.
